// File: rtl/object_plotter_if.sv
// Bus between a requester and the object plotter: plot request inputs
// plus the pixel stream toward the VGA adapter and the status flags.
interface object_plotter_if;
  logic       start_plot;
  logic [1:0] object;
  logic [7:0] new_x;
  logic [6:0] new_y;
  logic [7:0] old_x;
  logic [6:0] old_y;
  logic [7:0] size_x;
  logic [6:0] size_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;

  modport master (
    output start_plot, object, new_x, new_y, old_x, old_y, size_x, size_y,
    input  vga_x, vga_y, vga_colour, vga_plot, busy, done
  );

  modport slave (
    input  start_plot, object, new_x, new_y, old_x, old_y, size_x, size_y,
    output vga_x, vga_y, vga_colour, vga_plot, busy, done
  );
endinterface

// File: rtl/object_plotter.sv
// object_plotter: erases an object's old rectangle and redraws it at its new
// position, one pixel per cycle, raster order (x inner, y outer). Pixels
// beyond MAX_X/MAX_Y still take their cycle but are not written.
// Build option: define OBJECT_PLOTTER_ERASE_EN to include the erase pass;
// without it a request draws only and old_x/old_y are ignored.
module object_plotter #(
  parameter int         MAX_X         = 159,
  parameter int         MAX_Y         = 119,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter logic [2:0] BALL_COLOUR   = 3'b111,
  parameter logic [2:0] PADDLE_COLOUR = 3'b010,
  parameter logic [2:0] BLOCK_COLOUR  = 3'b100
) (
  input logic            clk,
  input logic            resetn,
  object_plotter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

`ifdef OBJECT_PLOTTER_ERASE_EN
  localparam state_t FIRST_PHASE = ERASE;
`else
  localparam state_t FIRST_PHASE = DRAW;
  // Corner of the erase rectangle has no consumer in draw-only builds.
  logic unused_old;
  assign unused_old = ^{bus.old_x, bus.old_y};
`endif

  state_t     state_q, state_d;
  logic [7:0] new_x_q, new_x_d, old_x_q, old_x_d, size_x_q, size_x_d;
  logic [6:0] new_y_q, new_y_d, old_y_q, old_y_d, size_y_q, size_y_d;
  logic [1:0] obj_q, obj_d;
  logic [7:0] cnt_x_q, cnt_x_d;
  logic [6:0] cnt_y_q, cnt_y_d;

  // Pixel address is formed one bit wider than the screen so an object
  // hanging off the right/bottom edge clips instead of wrapping to 0.
  logic [8:0] px;
  logic [7:0] py;
  logic       x_last, y_last;
  logic [2:0] draw_colour;

  // Next-state, counter advance and pixel outputs.
  always_comb begin
    state_d  = state_q;
    new_x_d  = new_x_q;
    new_y_d  = new_y_q;
    old_x_d  = old_x_q;
    old_y_d  = old_y_q;
    size_x_d = size_x_q;
    size_y_d = size_y_q;
    obj_d    = obj_q;
    cnt_x_d  = cnt_x_q;
    cnt_y_d  = cnt_y_q;

    bus.vga_x      = 8'd0;
    bus.vga_y      = 7'd0;
    bus.vga_colour = BG_COLOUR;
    bus.vga_plot   = 1'b0;
    bus.busy       = (state_q != IDLE);
    bus.done       = (state_q == DONE);

    if (state_q == ERASE) begin
      px = {1'b0, old_x_q} + {1'b0, cnt_x_q};
      py = {1'b0, old_y_q} + {1'b0, cnt_y_q};
    end else begin
      px = {1'b0, new_x_q} + {1'b0, cnt_x_q};
      py = {1'b0, new_y_q} + {1'b0, cnt_y_q};
    end
    x_last = (({1'b0, cnt_x_q} + 9'd1) == {1'b0, size_x_q});
    y_last = (({1'b0, cnt_y_q} + 8'd1) == {1'b0, size_y_q});

    case (obj_q)
      2'b00:   draw_colour = BALL_COLOUR;
      2'b01:   draw_colour = PADDLE_COLOUR;
      2'b10:   draw_colour = BLOCK_COLOUR;
      default: draw_colour = BG_COLOUR;
    endcase

    case (state_q)
      IDLE: begin
        if (bus.start_plot && (bus.object != 2'b11)) begin
          new_x_d  = bus.new_x;
          new_y_d  = bus.new_y;
`ifdef OBJECT_PLOTTER_ERASE_EN
          old_x_d  = bus.old_x;
          old_y_d  = bus.old_y;
`endif
          size_x_d = bus.size_x;
          size_y_d = bus.size_y;
          obj_d    = bus.object;
          cnt_x_d  = 8'd0;
          cnt_y_d  = 7'd0;
          if ((bus.size_x == 8'd0) || (bus.size_y == 7'd0))
            state_d = DONE;
          else
            state_d = FIRST_PHASE;
        end
      end
      ERASE, DRAW: begin
        bus.vga_x      = px[7:0];
        bus.vga_y      = py[6:0];
        bus.vga_colour = (state_q == ERASE) ? BG_COLOUR : draw_colour;
        bus.vga_plot   = (px <= 9'(MAX_X)) && (py <= 8'(MAX_Y));
        if (x_last) begin
          cnt_x_d = 8'd0;
          cnt_y_d = cnt_y_q + 7'd1;
        end else begin
          cnt_x_d = cnt_x_q + 8'd1;
        end
        if (x_last && y_last) begin
          cnt_x_d = 8'd0;
          cnt_y_d = 7'd0;
          state_d = (state_q == ERASE) ? DRAW : DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and raster counters; cleared at once on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      new_x_q  <= 8'd0;
      new_y_q  <= 7'd0;
      old_x_q  <= 8'd0;
      old_y_q  <= 7'd0;
      size_x_q <= 8'd0;
      size_y_q <= 7'd0;
      obj_q    <= 2'b00;
      cnt_x_q  <= 8'd0;
      cnt_y_q  <= 7'd0;
    end else begin
      state_q  <= state_d;
      new_x_q  <= new_x_d;
      new_y_q  <= new_y_d;
      old_x_q  <= old_x_d;
      old_y_q  <= old_y_d;
      size_x_q <= size_x_d;
      size_y_q <= size_y_d;
      obj_q    <= obj_d;
      cnt_x_q  <= cnt_x_d;
      cnt_y_q  <= cnt_y_d;
    end
  end

endmodule

// File: tb/tb_object_plotter.sv
// Directed bench for object_plotter; expectations follow the build option
// OBJECT_PLOTTER_ERASE_EN so the same file covers both configurations.
module tb_object_plotter;
  logic clk;
  logic resetn;
  object_plotter_if bus();

  object_plotter dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef OBJECT_PLOTTER_ERASE_EN
  localparam bit ERASE = 1'b1;
`else
  localparam bit ERASE = 1'b0;
`endif

  // Capture of one operation
  int         n_pix;
  logic [7:0] got_x [64];
  logic [6:0] got_y [64];
  logic [2:0] got_c [64];
  int         busy_cycles, done_cycle, done_count, first_plot;

  // Drive a request now; accepted at the next rising edge. Inputs are then
  // scrambled, and pixels/busy/done are recorded per cycle until done.
  task automatic issue(input logic [1:0] obj, input logic [7:0] nx, input logic [6:0] ny,
                       input logic [7:0] ox, input logic [6:0] oy,
                       input logic [7:0] sx, input logic [6:0] sy, input int repulse_at);
    bus.object = obj; bus.new_x = nx; bus.new_y = ny; bus.old_x = ox; bus.old_y = oy;
    bus.size_x = sx; bus.size_y = sy; bus.start_plot = 1'b1;
    @(posedge clk); #1;
    bus.start_plot = 1'b0;
    bus.new_x = 8'd3; bus.new_y = 7'd100; bus.old_x = 8'd200; bus.old_y = 7'd1;
    bus.size_x = 8'd9; bus.size_y = 7'd9; bus.object = 2'b10;
    n_pix = 0; busy_cycles = 0; done_cycle = 0; done_count = 0; first_plot = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (bus.busy) busy_cycles++;
      if (bus.vga_plot) begin
        if (first_plot == 0) first_plot = c;
        if (n_pix < 64) begin
          got_x[n_pix] = bus.vga_x; got_y[n_pix] = bus.vga_y; got_c[n_pix] = bus.vga_colour;
        end
        n_pix++;
      end
      if (bus.done) begin
        done_count++; done_cycle = c;
        break;
      end
      if (c == repulse_at) begin
        bus.start_plot = 1'b1; bus.object = 2'b00;
      end else begin
        bus.start_plot = 1'b0;
      end
    end
    bus.start_plot = 1'b0;
    $display("txn obj=%0d new=(%0d,%0d) size=%0dx%0d: pixels=%0d busy=%0d done_cycle=%0d",
             obj, nx, ny, sx, sy, n_pix, busy_cycles, done_cycle);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    bus.start_plot = 1'b0; bus.object = 2'b11;
    bus.new_x = 8'd0; bus.new_y = 7'd0; bus.old_x = 8'd0; bus.old_y = 7'd0;
    bus.size_x = 8'd0; bus.size_y = 7'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== 18'd0) begin
      n_bad++; $display("FAIL reset_pixel got x=%0d y=%0d c=%0d exp 0,0,0", bus.vga_x, bus.vga_y, bus.vga_colour);
    end
    n_cmp++;
    if ({bus.vga_plot, bus.busy, bus.done} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags got plot/busy/done=%b exp 000", {bus.vga_plot, bus.busy, bus.done});
    end
    resetn = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_ball;
    int ex[], ey[], ec[];
    int exp_busy;
    if (ERASE) begin
      ex = '{50, 51, 50, 51, 51, 52, 51, 52};
      ey = '{24, 24, 25, 25, 25, 25, 26, 26};
      ec = '{0, 0, 0, 0, 7, 7, 7, 7};
      exp_busy = 9;
    end else begin
      ex = '{51, 52, 51, 52};
      ey = '{25, 25, 26, 26};
      ec = '{7, 7, 7, 7};
      exp_busy = 5;
    end
    @(negedge clk);
    issue(2'b00, 8'd51, 7'd25, 8'd50, 7'd24, 8'd2, 7'd2, 0);
    n_cmp++;
    if (n_pix !== ex.size()) begin
      n_bad++; $display("FAIL ball_npix got %0d exp %0d", n_pix, ex.size());
    end
    for (int i = 0; i < ex.size(); i++) begin
      n_cmp++;
      if (int'(got_x[i]) !== ex[i] || int'(got_y[i]) !== ey[i] || int'(got_c[i]) !== ec[i]) begin
        n_bad++;
        $display("FAIL ball_pix%0d got (%0d,%0d,c%0d) exp (%0d,%0d,c%0d)",
                 i, got_x[i], got_y[i], got_c[i], ex[i], ey[i], ec[i]);
      end
    end
    n_cmp++;
    if (first_plot !== 1) begin
      n_bad++; $display("FAIL ball_first_plot got cycle %0d exp 1", first_plot);
    end
    n_cmp++;
    if (done_cycle !== exp_busy || busy_cycles !== exp_busy) begin
      n_bad++; $display("FAIL ball_timing got done=%0d busy=%0d exp %0d", done_cycle, busy_cycles, exp_busy);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_bad++; $display("FAIL ball_idle got busy/done=%b exp 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_paddle_clip;
    int ne, exp_done, k;
    ne = ERASE ? 16 : 0;
    exp_done = ne + 16 + 1;
    @(negedge clk);
    issue(2'b01, 8'd150, 7'd2, 8'd0, 7'd0, 8'd16, 7'd1, 0);
    n_cmp++;
    if (n_pix !== ne + 10) begin
      n_bad++; $display("FAIL paddle_npix got %0d exp %0d", n_pix, ne + 10);
    end
    for (int i = 0; i < ne + 10; i++) begin
      k = (i < ne) ? i : 150 + (i - ne);
      n_cmp++;
      if (int'(got_x[i]) !== k || int'(got_y[i]) !== ((i < ne) ? 0 : 2) ||
          int'(got_c[i]) !== ((i < ne) ? 0 : 2)) begin
        n_bad++;
        $display("FAIL paddle_pix%0d got (%0d,%0d,c%0d) exp (%0d,%0d,c%0d)", i, got_x[i], got_y[i],
                 got_c[i], k, (i < ne) ? 0 : 2, (i < ne) ? 0 : 2);
      end
    end
    n_cmp++;
    if (done_cycle !== exp_done || busy_cycles !== exp_done) begin
      n_bad++; $display("FAIL paddle_timing got done=%0d busy=%0d exp %0d", done_cycle, busy_cycles, exp_done);
    end
  endtask

  task automatic test_zero_size;
    @(negedge clk);
    issue(2'b10, 8'd20, 7'd20, 8'd30, 7'd30, 8'd0, 7'd5, 0);
    n_cmp++;
    if (n_pix !== 0) begin
      n_bad++; $display("FAIL zero_npix got %0d exp 0", n_pix);
    end
    n_cmp++;
    if (done_cycle !== 1 || busy_cycles !== 1) begin
      n_bad++; $display("FAIL zero_timing got done=%0d busy=%0d exp 1", done_cycle, busy_cycles);
    end
  endtask

  task automatic test_ignore;
    int busy_seen, extra_done, exp_done;
    exp_done = ERASE ? 13 : 7;
    // object=11 in IDLE must not start anything
    @(negedge clk);
    bus.object = 2'b11; bus.new_x = 8'd5; bus.new_y = 7'd5; bus.size_x = 8'd2; bus.size_y = 7'd2;
    bus.start_plot = 1'b1;
    @(negedge clk);
    bus.start_plot = 1'b0;
    busy_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy || bus.vga_plot) busy_seen++;
    end
    n_cmp++;
    if (busy_seen !== 0) begin
      n_bad++; $display("FAIL ignore_obj11 got %0d busy cycles exp 0", busy_seen);
    end
    $display("txn obj=3 request: busy cycles=%0d", busy_seen);
    // re-pulse during DRAW
    issue(2'b10, 8'd10, 7'd10, 8'd20, 7'd20, 8'd3, 7'd2, ERASE ? 8 : 3);
    n_cmp++;
    if (n_pix !== (ERASE ? 12 : 6)) begin
      n_bad++; $display("FAIL ignore_npix got %0d exp %0d", n_pix, ERASE ? 12 : 6);
    end
    n_cmp++;
    if (done_cycle !== exp_done || done_count !== 1) begin
      n_bad++; $display("FAIL ignore_done got cycle=%0d count=%0d exp %0d,1", done_cycle, done_count, exp_done);
    end
    n_cmp++;
    if (int'(got_x[n_pix-1]) !== 12 || int'(got_y[n_pix-1]) !== 11 || int'(got_c[n_pix-1]) !== 4) begin
      n_bad++; $display("FAIL ignore_last_pix got (%0d,%0d,c%0d) exp (12,11,c4)",
                        got_x[n_pix-1], got_y[n_pix-1], got_c[n_pix-1]);
    end
    busy_seen = 0; extra_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
      if (bus.done) extra_done++;
    end
    n_cmp++;
    if (busy_seen !== 0 || extra_done !== 0) begin
      n_bad++; $display("FAIL ignore_queued got busy=%0d done=%0d exp 0,0", busy_seen, extra_done);
    end
  endtask

  task automatic test_reset_mid;
    int bad_flags;
    @(negedge clk);
    bus.object = 2'b00; bus.new_x = 8'd51; bus.new_y = 7'd25; bus.old_x = 8'd50; bus.old_y = 7'd24;
    bus.size_x = 8'd2; bus.size_y = 7'd2; bus.start_plot = 1'b1;
    @(posedge clk); #1;
    bus.start_plot = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.vga_plot !== 1'b1 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_active got plot=%b busy=%b exp 1,1", bus.vga_plot, bus.busy);
    end
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.busy, bus.done} !== 21'd0) begin
      n_bad++; $display("FAIL rstmid_async got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b exp all 0",
                        bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot, bus.busy, bus.done);
    end
    bad_flags = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.vga_plot) bad_flags++;
    end
    n_cmp++;
    if (bad_flags !== 0) begin
      n_bad++; $display("FAIL rstmid_held got %0d active samples exp 0", bad_flags);
    end
    $display("txn reset mid-operation: active samples during reset=%0d", bad_flags);
    resetn = 1'b1;
    issue(2'b00, 8'd51, 7'd25, 8'd50, 7'd24, 8'd2, 7'd2, 0);
    n_cmp++;
    if (n_pix !== (ERASE ? 8 : 4) || done_cycle !== (ERASE ? 9 : 5) || done_count !== 1) begin
      n_bad++; $display("FAIL rstmid_after got pix=%0d done=%0d count=%0d exp %0d,%0d,1",
                        n_pix, done_cycle, done_count, ERASE ? 8 : 4, ERASE ? 9 : 5);
    end
  endtask

  initial begin
    test_reset();
    test_ball();
    test_paddle_clip();
    test_zero_size();
    test_ignore();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
